// File: rtl/stopwatch_ctrl_if.sv
// Bundles the stopwatch controller's button, counter and display signals.
// master drives buttons and live digits; slave is the controller side.
interface stopwatch_ctrl_if;
    logic       btn_ss;
    logic       btn_lap;
    logic       btn_clr;
    logic [3:0] cnt_d3;
    logic [3:0] cnt_d2;
    logic [3:0] cnt_d1;
    logic [3:0] cnt_d0;
    logic       cnt_en;
    logic       cnt_clr;
    logic [3:0] disp_d3;
    logic [3:0] disp_d2;
    logic [3:0] disp_d1;
    logic [3:0] disp_d0;
    logic [1:0] state;
    logic       lap_active;

    modport master (
        output btn_ss, btn_lap, btn_clr, cnt_d3, cnt_d2, cnt_d1, cnt_d0,
        input  cnt_en, cnt_clr, disp_d3, disp_d2, disp_d1, disp_d0, state, lap_active
    );

    modport slave (
        input  btn_ss, btn_lap, btn_clr, cnt_d3, cnt_d2, cnt_d1, cnt_d0,
        output cnt_en, cnt_clr, disp_d3, disp_d2, disp_d1, disp_d0, state, lap_active
    );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: debounces start/stop, lap and clear buttons, runs the
// run/pause/lap FSM, drives counter enable/clear and muxes live or frozen digits to the display.
module stopwatch_ctrl #(
    parameter int unsigned DB_CYCLES = 20000
) (
    input logic             clk,
    input logic             reset,
    stopwatch_ctrl_if.slave bus
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CntMax = CW'(DB_CYCLES - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRun   = 2'b01,
        StPause = 2'b10,
        StLap   = 2'b11
    } state_e;

    // Bit order: 0 = lap, 1 = start/stop, 2 = clear.
    logic [2:0] raw;
    logic [2:0] press;

    assign raw = {bus.btn_clr, bus.btn_ss, bus.btn_lap};

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic          sync1_q;
        logic          sync_q;
        logic          level_q;
        logic          level_prev_q;
        logic          press_q;
        logic [CW-1:0] cnt_q;

        always_ff @(posedge clk) begin
            if (reset) begin
                sync1_q      <= 1'b0;
                sync_q       <= 1'b0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                press_q      <= 1'b0;
                cnt_q        <= '0;
            end else begin
                sync1_q      <= raw[i];
                sync_q       <= sync1_q;
                level_prev_q <= level_q;
                press_q      <= level_q & ~level_prev_q;
                if (sync_q != level_q) begin
                    if (cnt_q == CntMax) begin
                        level_q <= sync_q;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end else begin
                    cnt_q <= '0;
                end
            end
        end

        assign press[i] = press_q;
    end

    logic        p_lap;
    logic        p_ss;
    logic        p_clr;
    logic [15:0] live;

    assign p_lap = press[0];
    assign p_ss  = press[1];
    assign p_clr = press[2];
    assign live  = {bus.cnt_d3, bus.cnt_d2, bus.cnt_d1, bus.cnt_d0};

    state_e      state_q;
    logic        cnt_en_q;
    logic        cnt_clr_q;
    logic [15:0] lap_q;

    // if/else ordering clr > ss > lap gives the priority; a won-but-ignored clr swallows the rest.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_en_q  <= 1'b0;
            cnt_clr_q <= 1'b0;
            lap_q     <= '0;
        end else begin
            cnt_clr_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (p_clr) begin
                        cnt_clr_q <= 1'b1;
                    end else if (p_ss) begin
                        state_q  <= StRun;
                        cnt_en_q <= 1'b1;
                    end
                end
                StRun: begin
                    if (!p_clr) begin
                        if (p_ss) begin
                            state_q  <= StPause;
                            cnt_en_q <= 1'b0;
                        end else if (p_lap) begin
                            state_q <= StLap;
                            lap_q   <= live;
                        end
                    end
                end
                StLap: begin
                    if (p_clr) begin
                        state_q <= StRun;
                    end else if (p_ss) begin
                        state_q  <= StPause;
                        cnt_en_q <= 1'b0;
                    end else if (p_lap) begin
                        lap_q <= live;
                    end
                end
                StPause: begin
                    if (p_clr) begin
                        state_q   <= StIdle;
                        cnt_clr_q <= 1'b1;
                    end else if (p_ss) begin
                        state_q  <= StRun;
                        cnt_en_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    logic lap_active;

    assign lap_active     = (state_q == StLap);
    assign bus.state      = state_q;
    assign bus.lap_active = lap_active;
    assign bus.cnt_en     = cnt_en_q;
    assign bus.cnt_clr    = cnt_clr_q;
    assign {bus.disp_d3, bus.disp_d2, bus.disp_d1, bus.disp_d0} = lap_active ? lap_q : live;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with DB_CYCLES=4: stimulus queues expected output
// snapshots with their cycle; a monitor pops one on every observed output change.
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    stopwatch_ctrl_if bus ();

    stopwatch_ctrl #(.DB_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [1:0]  st;
        logic        en;
        logic        clr;
        logic        lap;
        logic [15:0] disp;
    } snap_t;

    typedef struct {
        snap_t s;
        int    cyc;
        string name;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic expect_at(input string name, input logic [1:0] st, input logic en,
                             input logic clr, input logic [15:0] d, input int at);
        exp_t e;
        e.s.st   = st;
        e.s.en   = en;
        e.s.clr  = clr;
        e.s.lap  = (st == 2'b11);
        e.s.disp = d;
        e.cyc    = at;
        e.name   = name;
        sb.push_back(e);
    endtask

    task automatic set_dig(input logic [15:0] v);
        {bus.cnt_d3, bus.cnt_d2, bus.cnt_d1, bus.cnt_d0} = v;
    endtask

    // mask = {clr, ss, lap}; leaves enough idle cycles for the release to settle.
    task automatic press(input logic [2:0] mask, input int hold);
        bus.btn_clr = mask[2];
        bus.btn_ss  = mask[1];
        bus.btn_lap = mask[0];
        repeat (hold) @(negedge clk);
        bus.btn_clr = 1'b0;
        bus.btn_ss  = 1'b0;
        bus.btn_lap = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Monitor: every change of the output snapshot is a DUT event to be scored.
    initial begin
        snap_t prev;
        snap_t cur;
        exp_t  e;
        bit    first;
        prev  = '0;
        first = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            cur = {bus.state, bus.cnt_en, bus.cnt_clr, bus.lap_active,
                   bus.disp_d3, bus.disp_d2, bus.disp_d1, bus.disp_d0};
            if (first || cur !== prev) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h at cyc %0d, want no change", cur, cyc);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e.s || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL %s: got %h at cyc %0d, want %h at cyc %0d",
                                 e.name, cur, cyc, e.s, e.cyc);
                    end
                end
                prev  = cur;
                first = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.btn_ss  = 1'b0;
        bus.btn_lap = 1'b0;
        bus.btn_clr = 1'b0;
        set_dig(16'h0000);
        expect_at("reset", 2'b00, 1'b0, 1'b0, 16'h0000, 1);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // 1: clean start/stop press, FSM moves one edge after the 7-cycle press pulse
        expect_at("t1_run", 2'b01, 1'b1, 1'b0, 16'h0000, cyc + 8);
        press(3'b010, 10);

        // 2: 3-cycle glitch must be rejected
        press(3'b010, 3);

        // 3: lap freezes display, clr in LAP returns to live RUN
        set_dig(16'h0123);
        expect_at("t3_live", 2'b01, 1'b1, 1'b0, 16'h0123, cyc + 1);
        @(negedge clk);
        expect_at("t3_lap", 2'b11, 1'b1, 1'b0, 16'h0123, cyc + 8);
        press(3'b001, 6);
        set_dig(16'h0140);
        @(negedge clk);
        set_dig(16'h0150);
        @(negedge clk);
        expect_at("t3_clr_run", 2'b01, 1'b1, 1'b0, 16'h0150, cyc + 8);
        press(3'b100, 6);

        // 4: pause then clear gives one-cycle cnt_clr; clr in RUN is ignored
        expect_at("t4_pause", 2'b10, 1'b0, 1'b0, 16'h0150, cyc + 8);
        press(3'b010, 6);
        expect_at("t4_clr", 2'b00, 1'b0, 1'b1, 16'h0150, cyc + 8);
        expect_at("t4_clr_end", 2'b00, 1'b0, 1'b0, 16'h0150, cyc + 9);
        press(3'b100, 6);
        set_dig(16'h0000);
        expect_at("t4_live", 2'b00, 1'b0, 1'b0, 16'h0000, cyc + 1);
        @(negedge clk);
        expect_at("t4_run", 2'b01, 1'b1, 1'b0, 16'h0000, cyc + 8);
        press(3'b010, 6);
        press(3'b100, 6);

        // 5: clr+lap in RUN -> clr wins and is ignored; ss+clr in PAUSE -> clear
        press(3'b101, 6);
        expect_at("t5_pause", 2'b10, 1'b0, 1'b0, 16'h0000, cyc + 8);
        press(3'b010, 6);
        expect_at("t5_clr", 2'b00, 1'b0, 1'b1, 16'h0000, cyc + 8);
        expect_at("t5_clr_end", 2'b00, 1'b0, 1'b0, 16'h0000, cyc + 9);
        press(3'b110, 6);

        // 6: reset while in LAP with lap held; requalified press is ignored in IDLE
        expect_at("t6_run", 2'b01, 1'b1, 1'b0, 16'h0000, cyc + 8);
        press(3'b010, 6);
        set_dig(16'h0042);
        expect_at("t6_live", 2'b01, 1'b1, 1'b0, 16'h0042, cyc + 1);
        @(negedge clk);
        expect_at("t6_lap", 2'b11, 1'b1, 1'b0, 16'h0042, cyc + 8);
        press(3'b001, 6);
        bus.btn_lap = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        expect_at("t6_reset", 2'b00, 1'b0, 1'b0, 16'h0042, cyc + 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        bus.btn_lap = 1'b0;
        repeat (8) @(negedge clk);

        // clr in IDLE still pulses cnt_clr
        expect_at("idle_clr", 2'b00, 1'b0, 1'b1, 16'h0042, cyc + 8);
        expect_at("idle_clr_end", 2'b00, 1'b0, 1'b0, 16'h0042, cyc + 9);
        press(3'b100, 6);

        repeat (10) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d unseen expected events, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
